// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED sequencer.
// Holds the pattern and FSM enums plus the step-count helper.
package led_seq_pkg;

  localparam int PERIOD_W = 8;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_SOLID = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_CHASE = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // A period of zero behaves like a period of one.
  function automatic logic [PERIOD_W-1:0] step_last(input logic [PERIOD_W-1:0] period);
    if (period == {PERIOD_W{1'b0}}) begin
      step_last = {PERIOD_W{1'b0}};
    end else begin
      step_last = period - {{(PERIOD_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: counts 0..CLK_DIV-1 while enabled and flags the terminal count.
// The tick is asserted for one cycle, while the count sits at CLK_DIV-1.
module led_tick_gen #(
  parameter int CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  // Free-running divider; clr has priority over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= {CW{1'b0}};
    end else if (clr) begin
      count <= {CW{1'b0}};
    end else if (en) begin
      count <= (count == LAST) ? {CW{1'b0}} : count + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign tick = en & (count == LAST);

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: accepts a mode/period configuration and plays
// OFF/SOLID/BLINK/CHASE patterns on the LED outputs.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int CLK_DIV  = 50000,
  parameter int NUM_LEDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                on,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [1:0]          cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  output logic [NUM_LEDS-1:0] led,
  output logic                busy
);

  localparam logic [NUM_LEDS-1:0] ONE_HOT = {{(NUM_LEDS-1){1'b0}}, 1'b1};

  state_t              state;
  mode_t               mode;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] step;
  logic                loaded;
  logic [NUM_LEDS-1:0] pat;
  logic                tick;
  logic                accept;

  function automatic logic [NUM_LEDS-1:0] init_pattern(input mode_t m);
    case (m)
      MODE_OFF:   init_pattern = {NUM_LEDS{1'b0}};
      MODE_SOLID: init_pattern = {NUM_LEDS{1'b1}};
      MODE_BLINK: init_pattern = {NUM_LEDS{1'b1}};
      MODE_CHASE: init_pattern = ONE_HOT;
      default:    init_pattern = {NUM_LEDS{1'b0}};
    endcase
  endfunction

  function automatic logic [NUM_LEDS-1:0] next_pattern(input mode_t m,
                                                       input logic [NUM_LEDS-1:0] p);
    case (m)
      MODE_BLINK: next_pattern = ~p;
      MODE_CHASE: next_pattern = {p[NUM_LEDS-2:0], p[NUM_LEDS-1]};
      default:    next_pattern = p;
    endcase
  endfunction

  assign cfg_ready = on & ~rst & (state != ST_LOAD);
  assign accept    = cfg_valid & cfg_ready;

  led_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == ST_LOAD),
    .en   (state == ST_RUN),
    .tick (tick)
  );

  // led follows the internal pattern register one cycle later, so a config
  // accepted at edge N shows its first pattern after edge N+2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      mode   <= MODE_OFF;
      period <= {{(PERIOD_W-1){1'b0}}, 1'b1};
      step   <= {PERIOD_W{1'b0}};
      loaded <= 1'b0;
      pat    <= {NUM_LEDS{1'b0}};
      led    <= {NUM_LEDS{1'b0}};
      busy   <= 1'b0;
    end else if (!on) begin
      state <= ST_IDLE;
      led   <= {NUM_LEDS{1'b0}};
      busy  <= 1'b0;
    end else if (accept) begin
      mode   <= mode_t'(cfg_mode);
      period <= cfg_period;
      loaded <= 1'b1;
      state  <= ST_LOAD;
      busy   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          led <= {NUM_LEDS{1'b0}};
          if (loaded) begin
            state <= ST_LOAD;
            busy  <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_LOAD: begin
          pat   <= init_pattern(mode);
          step  <= {PERIOD_W{1'b0}};
          state <= ST_RUN;
          busy  <= 1'b1;
        end
        ST_RUN: begin
          led <= pat;
          if (tick) begin
            if (step == step_last(period)) begin
              step <= {PERIOD_W{1'b0}};
              pat  <= next_pattern(mode, pat);
            end else begin
              step <= step + {{(PERIOD_W-1){1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          led   <= {NUM_LEDS{1'b0}};
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter CLK_DIV, default 50000: clk cycles per tick; legal values are 2 or greater.
REQ-002 Parameter NUM_LEDS, default 4: LED output width; legal values are 2 or greater.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 on  input  1  global enable; low forces LEDs dark.
REQ-006 cfg_valid  input  1  configuration offer.
REQ-007 cfg_ready  output  1  configuration acceptance.
REQ-008 cfg_mode  input  2  pattern: 0 OFF, 1 SOLID, 2 BLINK, 3 CHASE.
REQ-009 cfg_period  input  8  ticks per pattern step; 0 treated as 1.
REQ-010 led  output  NUM_LEDS  registered LED drive, 1 = lit.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD and RUN.
REQ-013 The handshake SHALL transfer configuration on any rising clk edge where cfg_valid=1 and cfg_ready=1.
REQ-014 cfg_ready SHALL equal on AND (state != LOAD).
REQ-015 An accepted configuration SHALL set the cfg_loaded flag and move the FSM to LOAD from any state.
- Acceptance in RUN restarts the pattern.
REQ-016 In IDLE with on=1 and cfg_loaded=1, the FSM SHALL go to LOAD without a new handshake.
- This resumes the stored configuration.
REQ-017 LOAD SHALL last exactly one cycle and then go to RUN. On that cycle it SHALL:
- clear the prescaler and the step counter;
- load the initial pattern.
REQ-018 Initial patterns SHALL be:
- OFF: all 0;
- SOLID: all 1;
- BLINK: all 1;
- CHASE: one-hot bit 0.
REQ-019 Latency: configuration accepted at edge N SHALL have its initial pattern on led after edge N+2.
REQ-020 The prescaler SHALL count 0..CLK_DIV-1 in RUN only, wrapping to 0.
- It SHALL emit a one-cycle tick on the cycle its count equals CLK_DIV-1.
REQ-021 The step counter SHALL count ticks from 0 up to max(cfg_period,1)-1, wrapping to 0.
- The cycle it wraps is a step.
REQ-022 On each step:
- BLINK SHALL invert all LED bits;
- CHASE SHALL rotate left by one, with the MSB wrapping to bit 0;
- OFF and SOLID SHALL hold.
REQ-023 on=0 SHALL move the FSM to IDLE on the next edge, with led=0 after that edge.
- It SHALL take priority over every other transition.
- cfg_loaded and the stored configuration SHALL be retained.
REQ-024 In IDLE, led SHALL be 0.
REQ-025 Only one LED SHALL ever be lit in CHASE mode.

Reset
REQ-026 Asserting rst SHALL force the following immediately and asynchronously:
- state=IDLE;
- led=0, busy=0, cfg_ready=0;
- prescaler, step counter and cfg_loaded cleared;
- stored configuration set to OFF with period 1.
REQ-027 Reset deassertion SHALL be synchronised externally; the block SHALL leave IDLE no earlier than the first edge after rst falls.
REQ-028 Reset mid-RUN SHALL discard the stored configuration; a new handshake is then required.

Structure
REQ-029 Package led_seq_pkg SHALL hold:
- the mode enum (OFF, SOLID, BLINK, CHASE);
- the state enum (IDLE, LOAD, RUN);
- the period width constant (8).
REQ-030 The prescaler SHALL be a sub-module led_tick_gen with:
- parameter CLK_DIV;
- ports clk, rst, clr, en, tick.
REQ-031 All outputs except cfg_ready SHALL be driven directly from flops.

Verification (CLK_DIV=4, NUM_LEDS=4)
REQ-032 The bench SHALL cover reset and idle:
- rst pulse mid-RUN -> led=0000 and busy=0 immediately;
- afterwards, on=1 with no cfg -> stays IDLE.
REQ-033 The bench SHALL cover CHASE:
- stimulus: cfg mode=3, period=2;
- led=0001 two edges after acceptance;
- then 0010, 0100, 1000, 0001, each 8 cycles apart.
REQ-034 The bench SHALL cover BLINK:
- stimulus: mode=2, period=0;
- led=1111, then toggles to 0000 and back every 4 cycles.
REQ-035 The bench SHALL cover on dropping and resuming:
- on=0 mid-CHASE -> led=0000 next edge, busy=0;
- on=1 -> LOAD then led=0001 with no handshake.
REQ-036 The bench SHALL cover reconfiguration and simultaneous events:
- new cfg accepted during RUN -> pattern restarts at its initial value;
- cfg_valid with on=0 -> not accepted (cfg_ready=0), state stays IDLE.
